// File: rtl/seq_det_pkg.sv
// Shared definitions for the serializer / 101-detector slice: FSM state
// encoding and the default serial word width.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam int DEFAULT_W = 8;

endpackage

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with a valid/ready input handshake.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
   import seq_det_pkg::*;
#(
   parameter int   W      = DEFAULT_W,
   parameter logic IDLE_X = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic         x,
   output logic         x_valid,
   output logic         done
);

   localparam int CW = $clog2(W);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   sh_q, sh_d;
   logic           x_q, x_d;
   logic           x_valid_q, x_valid_d;
   logic           din_ready_q, din_ready_d;
   logic           done_q, done_d;
   logic           accept;
`ifdef BIT_SERIALIZER_PARITY_EN
   logic           par_q, par_d;
`endif

   assign accept = din_valid && din_ready_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         x_q         <= IDLE_X;
         x_valid_q   <= 1'b0;
         din_ready_q <= 1'b0;
         done_q      <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         x_q         <= x_d;
         x_valid_q   <= x_valid_d;
         din_ready_q <= din_ready_d;
         done_q      <= done_d;
`ifdef BIT_SERIALIZER_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   // A new word may be loaded from IDLE or from the final serial cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               cnt_d   = CW'(W - 1);
               sh_d    = din;
`ifdef BIT_SERIALIZER_PARITY_EN
               par_d   = ^din;
`endif
            end
         end
         SHIFT: begin
            if (cnt_q == '0) begin
`ifdef BIT_SERIALIZER_PARITY_EN
               state_d = PARITY;
`else
               if (accept) begin
                  state_d = SHIFT;
                  cnt_d   = CW'(W - 1);
                  sh_d    = din;
               end else begin
                  state_d = IDLE;
               end
`endif
            end else begin
               cnt_d = cnt_q - CW'(1);
               sh_d  = sh_q << 1;
            end
         end
`ifdef BIT_SERIALIZER_PARITY_EN
         PARITY: begin
            if (accept) begin
               state_d = SHIFT;
               cnt_d   = CW'(W - 1);
               sh_d    = din;
               par_d   = ^din;
            end else begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Outputs are derived from next-state values so that registering them
   // lines them up with the state they describe.
   always_comb begin
      x_d       = IDLE_X;
      x_valid_d = (state_d != IDLE);
      done_d    = 1'b0;
      case (state_d)
         SHIFT: begin
            x_d = sh_d[W-1];
`ifndef BIT_SERIALIZER_PARITY_EN
            done_d = (cnt_d == '0);
`endif
         end
`ifdef BIT_SERIALIZER_PARITY_EN
         PARITY: begin
            x_d    = par_d;
            done_d = 1'b1;
         end
`endif
         default: x_d = IDLE_X;
      endcase
      din_ready_d = (state_d == IDLE) || done_d;
   end

   assign x         = x_q;
   assign x_valid   = x_valid_q;
   assign din_ready = din_ready_q;
   assign done      = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: stimulus pushes expected serial bits,
// a negedge monitor pops and compares them; also models a 101 detector on x.
module tb_bit_serializer;

   localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB = W + PAR;

   typedef struct packed {
      logic x;
      logic done;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [W-1:0] din;
   logic         din_valid;
   logic         din_ready;
   logic         x;
   logic         x_valid;
   logic         done;

   exp_t expQ[$];
   int   errors = 0;
   int   checks = 0;
   int   runLen = 0;
   int   lastRun = 0;
   int   detState = 0;
   int   yCount = 0;
   int   yBit = 0;
   int   bitCnt = 0;
   bit   detEn = 1'b0;

   bit_serializer #(.W(W), .IDLE_X(1'b0)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .x         (x),
      .x_valid   (x_valid),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pushWord(input logic [W-1:0] d);
      exp_t e;
      for (int i = W - 1; i >= 0; i--) begin
         e.x    = d[i];
         e.done = (i == 0) && (PAR == 0);
         expQ.push_back(e);
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      e.x    = ^d;
      e.done = 1'b1;
      expQ.push_back(e);
`endif
   endtask

   // Called at a negedge; returns at the negedge after acceptance with din_valid still high.
   task automatic applyStimulus(input logic [W-1:0] d);
      int n = 0;
      din       = d;
      din_valid = 1'b1;
      while (!din_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!din_ready) begin
         checkOutput("ready_timeout", 32'(din_ready), 32'd1);
         return;
      end
      pushWord(d);
      @(negedge clk);
   endtask

   task automatic waitDrain();
      int n = 0;
      while (expQ.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", 32'(expQ.size()), 32'd0);
      repeat (2) @(negedge clk);
      #1;
   endtask

   // Monitor: compare each valid serial bit against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (x_valid) begin
         runLen++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_bit", 32'(x_valid), 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("x_bit", 32'(x), 32'(e.x));
            checkOutput("done_bit", 32'(done), 32'(e.done));
         end
         if (detEn) begin
            bitCnt++;
            if (detState == 2 && x) begin
               yCount++;
               yBit = bitCnt;
            end
            if (x) detState = 1;
            else   detState = (detState == 1) ? 2 : 0;
         end
      end else begin
         if (runLen > 0) lastRun = runLen;
         runLen = 0;
         checkOutput("done_idle", 32'(done), 32'd0);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst       = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      #1;
      checkOutput("rst_x", 32'(x), 32'd0);
      checkOutput("rst_x_valid", 32'(x_valid), 32'd0);
      checkOutput("rst_din_ready", 32'(din_ready), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("ready_before_edge", 32'(din_ready), 32'd0);
      @(negedge clk);
      checkOutput("ready_after_release", 32'(din_ready), 32'd1);

      // Single word 8'hA5
      applyStimulus(8'hA5);
      din_valid = 1'b0;
      repeat (NB - 1) @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("idle_x", 32'(x), 32'd0);
      checkOutput("idle_x_valid", 32'(x_valid), 32'd0);
      checkOutput("single_q_empty", 32'(expQ.size()), 32'd0);

      // Back-to-back 8'h05 then 8'hA0
      @(negedge clk);
      applyStimulus(8'h05);
      applyStimulus(8'hA0);
      din_valid = 1'b0;
      waitDrain();
      checkOutput("b2b_run", 32'(lastRun), 32'(2 * NB));

      // Holdoff: 8'hFF offered in cycle 3 of 8'hA5
      @(negedge clk);
      applyStimulus(8'hA5);
      @(negedge clk);
      @(negedge clk);
      din = 8'hFF;
      #1;
      checkOutput("holdoff_ready", 32'(din_ready), 32'd0);
      applyStimulus(8'hFF);
      din_valid = 1'b0;
      waitDrain();
      checkOutput("holdoff_run", 32'(lastRun), 32'(2 * NB));

      // Reset in cycle 4 of 8'hA5
      @(negedge clk);
      applyStimulus(8'hA5);
      din_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("midrst_x", 32'(x), 32'd0);
      checkOutput("midrst_x_valid", 32'(x_valid), 32'd0);
      checkOutput("midrst_done", 32'(done), 32'd0);
      checkOutput("midrst_ready", 32'(din_ready), 32'd0);
      expQ.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      applyStimulus(8'hA5);
      din_valid = 1'b0;
      waitDrain();
      checkOutput("post_rst_run", 32'(lastRun), 32'(NB));

`ifdef BIT_SERIALIZER_PARITY_EN
      // Parity words: 8'hA5 -> 0, 8'h07 -> 1
      @(negedge clk);
      applyStimulus(8'hA5);
      applyStimulus(8'h07);
      din_valid = 1'b0;
      waitDrain();
      checkOutput("parity_run", 32'(lastRun), 32'(2 * NB));
`endif

      // Chaining into a 101 detector
      detState = 0;
      yCount   = 0;
      yBit     = 0;
      bitCnt   = 0;
      detEn    = 1'b1;
      @(negedge clk);
      applyStimulus(8'b1010_0000);
      din_valid = 1'b0;
      waitDrain();
      detEn = 1'b0;
      checkOutput("det_y_count", 32'(yCount), 32'd1);
      checkOutput("det_y_bit", 32'(yBit), 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
